ghostbus_host: RTL and testbench

- Bus initiator that drives the ghostbus (gb_addr, gb_dout, gb_we) and samples the returned gb_din.
- Sits at the top of the ghostbus tree. Its bus outputs connect to the top-level module's ghostbus ports, so it feeds the entire decoded hierarchy.
- Accepts transaction requests from a command source (UART/Ethernet bridge) over a valid/ready interface.
- Returns read data over a valid/ready response stream; supports auto-incrementing read bursts.

---
 rtl/ghostbus_host.sv | 136 +++++++++++++
 tb/tb_ghostbus_host.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host.sv
// Ghostbus initiator: turns valid/ready requests into bus writes and
// latency-timed reads, with auto-incrementing read bursts and a response stream.
module ghostbus_host #(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             gb_clk,
  input  logic             gb_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic [AW-1:0]    gb_addr,
  output logic [DW-1:0]    gb_dout,
  input  logic [DW-1:0]    gb_din,
  output logic             gb_we,
  output logic             busy
);

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RSP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [LEN_W-1:0]   r_beats_left;
  logic [AW-1:0]      r_gb_addr;
  logic [DW-1:0]      r_gb_dout;
  logic               r_gb_we;
  logic               r_rsp_valid;
  logic [DW-1:0]      r_rsp_data;
  logic               r_rsp_last;

  logic               w_accept;
  logic               w_lat_done;
  logic               w_last_beat;

  assign w_accept    = req_valid & req_ready;
  assign w_lat_done  = (r_lat_cnt == '0);
  assign w_last_beat = (r_beats_left == '0);

  always_ff @(posedge gb_clk) begin
    if (gb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = req_we ? S_WRITE : S_RD_WAIT;
      S_WRITE:   w_state_nxt = S_IDLE;
      S_RD_WAIT: if (w_lat_done) w_state_nxt = S_RD_RSP;
      S_RD_RSP:  if (rsp_ready) w_state_nxt = w_last_beat ? S_IDLE : S_RD_WAIT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Only the request handshake and busy flag are combinational.
  always_comb begin
    req_ready = (r_state == S_IDLE) & ~gb_rst;
    busy      = (r_state != S_IDLE);
  end

  // Bus and response registers; gb_addr never moves until the beat is consumed.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      r_lat_cnt    <= '0;
      r_beats_left <= '0;
      r_gb_addr    <= '0;
      r_gb_dout    <= '0;
      r_gb_we      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gb_addr <= req_addr;
            if (req_we) begin
              r_gb_dout <= req_wdata;
              r_gb_we   <= 1'b1;
            end else begin
              r_lat_cnt    <= LAT_W'(RD_LAT);
              r_beats_left <= req_len;
            end
          end
        end
        S_WRITE: r_gb_we <= 1'b0;
        S_RD_WAIT: begin
          if (w_lat_done) begin
            r_rsp_data  <= gb_din;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= w_last_beat;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        S_RD_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            if (!w_last_beat) begin
              r_gb_addr    <= r_gb_addr + AW'(1);
              r_beats_left <= r_beats_left - LEN_W'(1);
              r_lat_cnt    <= LAT_W'(RD_LAT);
            end
          end
        end
        default: r_gb_we <= 1'b0;
      endcase
    end
  end

  assign gb_addr   = r_gb_addr;
  assign gb_dout   = r_gb_dout;
  assign gb_we     = r_gb_we;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_ghostbus_host.sv
// Bench for ghostbus_host: timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ghostbus_host;

  localparam int unsigned AW     = 12;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned LEN_W  = 8;

  localparam int M_IDLE = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;

  logic             gb_clk = 1'b0;
  logic             gb_rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_wdata = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [DW-1:0]    rsp_data;
  logic             rsp_last;
  logic [AW-1:0]    gb_addr;
  logic [DW-1:0]    gb_dout;
  logic [DW-1:0]    gb_din;
  logic             gb_we;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit rdy_rand = 1'b0;

  ghostbus_host #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .gb_addr(gb_addr), .gb_dout(gb_dout),
    .gb_din(gb_din), .gb_we(gb_we), .busy(busy)
  );

  always #5 gb_clk = ~gb_clk;

  // Peripheral contents: address 0 reads 0x42, everything else a hash.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == '0) return 32'h0000_0042;
    return {a, 20'h0} ^ (DW'(a) * 32'h9E37_79B1);
  endfunction

  // Responder: data appears RD_LAT cycles after the address it decodes.
  logic [DW-1:0] pipe [0:15];
  always @(posedge gb_clk) begin
    pipe[0] <= mem_val(gb_addr);
    for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
  end
  assign gb_din = pipe[RD_LAT-1];

  // Transaction model: each read beat starts at cycle m_t0 and shows data from m_t0+RD_LAT+1.
  int            cyc = 0;
  int            m_mode = M_IDLE;
  int            m_t0 = 0;
  int            m_beat = 0;
  int            m_len = 0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dout = '0;
  bit            m_init = 1'b0;

  function automatic bit mv();
    return (m_mode == M_RD) && (cyc >= m_t0 + int'(RD_LAT) + 1);
  endfunction

  always @(posedge gb_clk) begin
    if (gb_rst) begin
      m_mode <= M_IDLE;
      m_addr <= '0;
      m_dout <= '0;
      m_init <= 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (req_valid) begin
          m_addr <= req_addr;
          if (req_we) begin
            m_mode <= M_WR;
            m_dout <= req_wdata;
          end else begin
            m_mode <= M_RD;
            m_base <= req_addr;
            m_len  <= int'(req_len);
            m_beat <= 0;
            m_t0   <= cyc + 1;
          end
        end
        M_WR: m_mode <= M_IDLE;
        default: if (mv() && rsp_ready) begin
          if (m_beat == m_len) m_mode <= M_IDLE;
          else begin
            m_beat <= m_beat + 1;
            m_addr <= AW'(m_base + AW'(m_beat + 1));
            m_t0   <= cyc + 1;
          end
        end
      endcase
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge gb_clk) begin
    if (m_init) begin
      chk("gb_addr", 64'(gb_addr), 64'(m_addr));
      chk("gb_dout", 64'(gb_dout), 64'(m_dout));
      chk("gb_we", 64'(gb_we), 64'(m_mode == M_WR));
      chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
      chk("req_ready", 64'(req_ready), 64'((m_mode == M_IDLE) && !gb_rst));
      chk("rsp_valid", 64'(rsp_valid), 64'(mv()));
      chk("rsp_last", 64'(rsp_last), 64'(mv() && (m_beat == m_len)));
      if (mv()) chk("rsp_data", 64'(rsp_data), 64'(mem_val(m_addr)));
    end
  end

  task automatic step();
    @(posedge gb_clk);
    #2;
    if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic bit cond(input int what, input int arg);
    case (what)
      0:       return m_mode == M_IDLE;
      1:       return mv();
      default: return (m_mode == M_RD) && (m_beat == arg) && !mv();
    endcase
  endfunction

  task automatic wait_until(input int what, input int arg);
    int n = 0;
    while (!cond(what, arg)) begin
      step();
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL wait_timeout: condition %0d/%0d not reached, got none expected reached", what, arg);
        break;
      end
    end
  endtask

  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [LEN_W-1:0] len);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_len   = len;
    wait_until(0, 0);
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_len   = LEN_W'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge gb_clk);
    chk("rst_gb_addr", 64'(gb_addr), 64'h0);
    chk("rst_gb_we", 64'(gb_we), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    step();
    gb_rst = 1'b0;
    step();

    // Single write
    send(1'b1, 12'h040, 32'hDEAD_BEEF, 8'd0);
    @(negedge gb_clk);
    chk("wr_addr", 64'(gb_addr), 64'h040);
    chk("wr_dout", 64'(gb_dout), 64'hDEAD_BEEF);
    chk("wr_we", 64'(gb_we), 64'h1);
    step();
    @(negedge gb_clk);
    chk("wr_we_drop", 64'(gb_we), 64'h0);
    chk("wr_ready", 64'(req_ready), 64'h1);

    // Single read from address 0
    rsp_ready = 1'b1;
    send(1'b0, 12'h000, 32'h0, 8'd0);
    @(negedge gb_clk);
    chk("rd_addr", 64'(gb_addr), 64'h000);
    repeat (RD_LAT) step();
    @(negedge gb_clk);
    chk("rd_early_valid", 64'(rsp_valid), 64'h0);
    step();
    @(negedge gb_clk);
    chk("rd_valid", 64'(rsp_valid), 64'h1);
    chk("rd_data", 64'(rsp_data), 64'h42);
    chk("rd_last", 64'(rsp_last), 64'h1);
    wait_until(0, 0);

    // Burst with a 5-cycle stall on beat 1
    rsp_ready = 1'b0;
    send(1'b0, 12'h200, 32'h0, 8'd3);
    wait_until(1, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    wait_until(1, 0);
    repeat (5) begin
      @(negedge gb_clk);
      chk("stall_addr", 64'(gb_addr), 64'h201);
      chk("stall_valid", 64'(rsp_valid), 64'h1);
      chk("stall_last", 64'(rsp_last), 64'h0);
      step();
    end
    rsp_ready = 1'b1;
    wait_until(0, 0);

    // Address wrap
    send(1'b0, 12'hFFF, 32'h0, 8'd1);
    @(negedge gb_clk);
    chk("wrap_first", 64'(gb_addr), 64'hFFF);
    wait_until(2, 1);
    @(negedge gb_clk);
    chk("wrap_second", 64'(gb_addr), 64'h000);
    wait_until(0, 0);

    // Reset during beat 2 of an 8-beat burst
    send(1'b0, 12'h123, 32'h0, 8'd7);
    wait_until(2, 2);
    gb_rst = 1'b1;
    step();
    gb_rst = 1'b0;
    @(negedge gb_clk);
    chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_addr", 64'(gb_addr), 64'h000);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    send(1'b0, 12'h010, 32'h0, 8'd2);
    wait_until(0, 0);

    // Write then read held valid: read waits out the WRITE cycle
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 12'h055;
    req_wdata = 32'h1234_5678;
    step();
    req_we   = 1'b0;
    req_addr = 12'h066;
    req_len  = 8'd0;
    @(negedge gb_clk);
    chk("b2b_busy_ready", 64'(req_ready), 64'h0);
    chk("b2b_we", 64'(gb_we), 64'h1);
    step();
    @(negedge gb_clk);
    chk("b2b_idle_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 1'b0;
    repeat (RD_LAT) step();
    @(negedge gb_clk);
    chk("b2b_early_valid", 64'(rsp_valid), 64'h0);
    step();
    @(negedge gb_clk);
    chk("b2b_valid", 64'(rsp_valid), 64'h1);
    chk("b2b_data", 64'(rsp_data), 64'(mem_val(12'h066)));
    wait_until(0, 0);

    // Randomized traffic with random back-pressure and occasional resets
    rdy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
        0:       a = 12'hFFE;
        1:       a = 12'hFFF;
        default: a = AW'($urandom);
      endcase
      send(1'($urandom_range(0, 1)), a, $urandom, LEN_W'($urandom_range(0, 4)));
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(0, 4)) step();
        gb_rst = 1'b1;
        step();
        gb_rst = 1'b0;
      end else begin
        repeat ($urandom_range(0, 2)) step();
      end
    end
    rdy_rand  = 1'b0;
    rsp_ready = 1'b1;
    wait_until(0, 0);
    step();
    @(negedge gb_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
